// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an optional iterative shift-add multiplier.
//
// One operation is launched per Start strobe while the block is idle. Results
// and flags are registered; Done pulses for one cycle when they update.
//
// Handshake: Start is sampled only when Busy is low, and nothing is queued.
// A single-cycle op sampled at edge k shows Done=1 after edge k. A MUL sampled
// at edge k holds Busy=1 after edges k..k+WIDTH-1 and shows Done=1 with
// Busy=0 after edge k+WIDTH. Out/Branch/Zero/Carry hold between Done pulses.
//
// Build option: define ALU_SEQ_MUL_EN to compile in the multiplier (opcode 12).
// Without it, opcode 12 behaves as a reserved opcode and Busy stays 0.
//
// Ports:
//   Clk        clock, rising edge
//   Reset      asynchronous, active-high
//   Start      launch strobe (honoured in IDLE only)
//   OP         4-bit opcode
//   InputA/B   WIDTH-bit operands
//   Im         IMW-bit immediate / shift amount
//   Out        registered result
//   Branch     registered branch-taken flag (ops 10/11)
//   Zero       registered zero flag
//   Carry      registered carry (ADD/ADDI) or overflow (MUL)
//   Busy       multiplier in flight
//   Done       one-cycle result-update pulse
//   dbg_state  current FSM state (0 = IDLE, 1 = MUL)
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int IMW   = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       OP,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic [IMW-1:0]   Im,
   output logic [WIDTH-1:0] Out,
   output logic             Branch,
   output logic             Zero,
   output logic             Carry,
   output logic             Busy,
   output logic             Done,
   output logic             dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t state, state_d;

   logic [WIDTH-1:0] out_d;
   logic             branch_d, zero_d, carry_d, done_d;

   // Single-cycle datapath
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_br, alu_rsv;

   assign imm_ext = WIDTH'(Im);

   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_br  = 1'b0;
      alu_rsv = 1'b0;
      case (OP)
         4'd0: begin
            sum     = {1'b0, InputA} + {1'b0, InputB};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         4'd1: begin
            sum     = {1'b0, InputA} + {1'b0, imm_ext};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         4'd2:  alu_res = InputA << Im;
         4'd3:  alu_res = InputA >> Im;
         4'd4:  alu_res = InputA & InputB;
         4'd5:  alu_res = InputA | InputB;
         4'd6:  alu_res = '0 - InputA;
         4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (InputA >= InputB)};
         4'd8:  alu_res = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
         4'd9:  alu_res = {{(WIDTH-1){1'b0}}, (InputA != InputB)};
         4'd10,
         4'd11: alu_br  = |InputB;
         // Reserved opcodes (and 12 when the multiplier is absent) force
         // every flag low, including Zero, even though Out is 0.
         default: alu_rsv = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc, acc_d, mcand, mcand_d, acc_sum;
   logic [WIDTH-1:0]   mplier, mplier_d;
   logic [CW-1:0]      cnt, cnt_d;

   assign acc_sum = acc + (mplier[0] ? mcand : '0);
   assign Busy    = (state == S_MUL);
`else
   assign Busy    = 1'b0;
`endif

   assign dbg_state = state;

   // Next-state and output logic
   always_comb begin
      state_d  = state;
      out_d    = Out;
      branch_d = Branch;
      zero_d   = Zero;
      carry_d  = Carry;
      done_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_d    = acc;
      mcand_d  = mcand;
      mplier_d = mplier;
      cnt_d    = cnt;
`endif
      case (state)
         S_IDLE: begin
            if (Start) begin
`ifdef ALU_SEQ_MUL_EN
               if (OP == 4'd12) begin
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, InputA};
                  mplier_d = InputB;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else
`endif
               begin
                  out_d    = alu_res;
                  branch_d = alu_br;
                  carry_d  = alu_c;
                  zero_d   = (alu_res == '0) && !alu_rsv;
                  done_d   = 1'b1;
               end
            end
         end
`ifdef ALU_SEQ_MUL_EN
         S_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand << 1;
            mplier_d = mplier >> 1;
            cnt_d    = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               out_d    = acc_sum[WIDTH-1:0];
               carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
               branch_d = 1'b0;
               zero_d   = (acc_sum[WIDTH-1:0] == '0);
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= S_IDLE;
         Out    <= '0;
         Branch <= 1'b0;
         Zero   <= 1'b1;
         Carry  <= 1'b0;
         Done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
`endif
      end else begin
         state  <= state_d;
         Out    <= out_d;
         Branch <= branch_d;
         Zero   <= zero_d;
         Carry  <= carry_d;
         Done   <= done_d;
`ifdef ALU_SEQ_MUL_EN
         acc    <= acc_d;
         mcand  <= mcand_d;
         mplier <= mplier_d;
         cnt    <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8, IMW=3). Works with and without
// ALU_SEQ_MUL_EN defined.
module tb_alu_seq;

   localparam int W  = 8;
   localparam int IW = 3;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          Clk = 1'b0;
   logic          Reset, Start;
   logic [3:0]    OP;
   logic [W-1:0]  InputA, InputB;
   logic [IW-1:0] Im;
   logic [W-1:0]  Out;
   logic          Branch, Zero, Carry, Busy, Done, dbg_state;

   alu_seq #(.WIDTH(W), .IMW(IW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP),
      .InputA(InputA), .InputB(InputB), .Im(Im),
      .Out(Out), .Branch(Branch), .Zero(Zero), .Carry(Carry),
      .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   // ---------------- scoreboard ----------------
   // entry = {out, branch, zero, carry}
   logic [W+2:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain integer arithmetic on the opcode table.
   function automatic logic [W+2:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [IW-1:0] im);
      longint unsigned m  = 64'd1 << W;
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint unsigned r  = 0;
      bit c = 0, br = 0, rsv = 0;
      logic [W-1:0] o;
      case (op)
         4'd0:  begin r = ua + ub; c = (r >= m); end
         4'd1:  begin r = ua + im; c = (r >= m); end
         4'd2:  r = ua * (64'd1 << im);
         4'd3:  r = ua / (64'd1 << im);
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = m - ua;
         4'd7:  r = (ua >= ub) ? 1 : 0;
         4'd8:  r = (ua == ub) ? 1 : 0;
         4'd9:  r = (ua != ub) ? 1 : 0;
         4'd10, 4'd11: br = (ub != 0);
         4'd12: begin
            if (MUL_EN) begin r = ua * ub; c = (r >= m); end
            else rsv = 1;
         end
         default: rsv = 1;
      endcase
      r = r % m;
      o = r[W-1:0];
      return {o, br, (r == 0) && !rsv, c};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every Done pulse consumes one expected result.
   always @(negedge Clk) begin
      logic [W+2:0] e;
      if (!Reset && Done) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got Done=1 with out=%0h, expected no pending result", Out);
         end else begin
            e = exp_q.pop_front();
            if ({Out, Branch, Zero, Carry} !== e) begin
               n_fail++;
               $display("FAIL result: got out=%0h br=%0b z=%0b c=%0b expected out=%0h br=%0b z=%0b c=%0b",
                        Out, Branch, Zero, Carry, e[W+2:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic issue(input bit go, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [IW-1:0] im);
      Start = go; OP = op; InputA = a; InputB = b; Im = im;
      if (go && !Busy) exp_q.push_back(model(op, a, b, im));
      @(negedge Clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (Busy && t < 100) begin t++; @(negedge Clk); end
      if (t >= 100) check("busy_timeout", 32'(Busy), 32'd0);
   endtask

   task automatic mul_check(input logic [W-1:0] a, input logic [W-1:0] b);
      int cnt = 0;
      issue(1'b1, 4'd12, a, b, '0);
      Start = 1'b0;
      while (Busy && cnt < 100) begin cnt++; @(negedge Clk); end
      check("mul_busy_cycles", 32'(cnt), MUL_EN ? 32'(W) : 32'd0);
      check("mul_done", 32'(Done), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_out"},    32'(Out),    32'd0);
      check({tag, "_branch"}, 32'(Branch), 32'd0);
      check({tag, "_zero"},   32'(Zero),   32'd1);
      check({tag, "_carry"},  32'(Carry),  32'd0);
      check({tag, "_busy"},   32'(Busy),   32'd0);
      check({tag, "_done"},   32'(Done),   32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Reset = 1'b1; Start = 1'b0; OP = '0; InputA = '0; InputB = '0; Im = '0;
      repeat (2) @(negedge Clk);
      check_reset_vals("reset");
      Reset = 1'b0;
      @(negedge Clk);

      // ADD with carry and zero, then Done must drop
      issue(1'b1, 4'd0, 8'hFF, 8'h01, '0);
      Start = 1'b0;
      check("add_carry", 32'(Carry), 32'd1);
      @(negedge Clk);
      check("done_pulse", 32'(Done), 32'd0);
      check("hold_out", 32'(Out), 32'd0);

      // Shifts, NEG, branches
      issue(1'b1, 4'd2, 8'h81, 8'h00, 3'd1);
      issue(1'b1, 4'd2, 8'h81, 8'h00, 3'd0);
      issue(1'b1, 4'd3, 8'h80, 8'h00, 3'd7);
      issue(1'b1, 4'd6, 8'h05, 8'h00, 3'd0);
      check("back_to_back_done", 32'(Done), 32'd1);
      issue(1'b1, 4'd10, 8'h33, 8'h00, 3'd0);
      issue(1'b1, 4'd11, 8'h33, 8'h10, 3'd0);
      check("bnzr_branch", 32'(Branch), 32'd1);
      issue(1'b1, 4'd14, 8'h12, 8'h34, 3'd2);
      Start = 1'b0;
      @(negedge Clk);

      // Multiplier
      mul_check(8'd13, 8'd11);
      mul_check(8'd20, 8'd20);

      // Start with ADD and changed operands while a MUL is in flight
      issue(1'b1, 4'd12, 8'd13, 8'd11, '0);
      Start = 1'b0;
      @(negedge Clk);
      issue(1'b1, 4'd0, 8'h55, 8'h66, '0);
      Start = 1'b0; InputA = 8'hAA; InputB = 8'h01;
      wait_idle();
      @(negedge Clk);

      // Reset during cycle 4 of a MUL
      issue(1'b1, 4'd12, 8'd13, 8'd11, '0);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      #2 Reset = 1'b1;
      #1 check_reset_vals("mid_mul_reset");
      exp_q.delete();
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      issue(1'b1, 4'd0, 8'd2, 8'd3, '0);
      Start = 1'b0;
      check("add_after_reset", 32'(Out), 32'd5);

      // Randomized traffic, including Starts issued while Busy
      for (int i = 0; i < 400; i++) begin
         issue(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
               W'($urandom), W'($urandom), IW'($urandom));
      end
      Start = 1'b0;

      // Drain
      for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge Clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
